sub_word_engine: RTL and testbench

Parametrised, time-multiplexed byte-substitution engine for the AES datapath. It is the sequential successor to the four-lane combinational word substitution used in key expansion. It takes a BYTES-wide word over a valid/ready handshake and runs it through LANES S-box lanes per cycle, using either the forward or the inverse S-box. It can optionally apply RotWord before substitution and an Rcon XOR after it, so one instance serves the key-schedule g function (BYTES=4) and full-state SubBytes/InvSubBytes (BYTES=16).

---
 rtl/sub_word_engine.sv | 192 +++++++++++++++++++
 tb/tb_sub_word_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_word_engine.sv
// sub_word_engine: time-multiplexed AES byte substitution over a valid/ready handshake.
// A BYTES-wide word is captured (optionally RotWord-ed), then LANES bytes per cycle are
// replaced in place by S(b) or InvS(b); byte 0 is additionally XORed with the latched Rcon.
// The finished word is held in HOLD until the downstream handshake completes.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_valid / o_ready   input handshake; o_ready only in IDLE and out of reset
//   i_word              input word, byte k = i_word[8k+7:8k]
//   i_inverse, i_rot    inverse S-box select, RotWord enable (sampled at accept)
//   i_rcon              XORed into output byte 0 (sampled at accept)
//   o_valid / i_ready   output handshake
//   o_word              working register, meaningful while o_valid=1
module sub_word_engine #(
    parameter int unsigned BYTES = 4,
    parameter int unsigned LANES = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [8*BYTES-1:0] i_word,
    input  logic               i_inverse,
    input  logic               i_rot,
    input  logic [7:0]         i_rcon,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [8*BYTES-1:0] o_word
);

    if (LANES == 0 || (BYTES % LANES) != 0) begin : g_param_check
        $error("sub_word_engine: BYTES must be a non-zero multiple of LANES");
    end

    localparam int unsigned Chunks = BYTES / LANES;
    localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;

    localparam logic [7:0] FwdSbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] InvSbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {StIdle, StSub, StHold} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [8*BYTES-1:0] work_q, work_d;
    logic               inv_q, inv_d;
    logic [7:0]         rcon_q, rcon_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            inv_q   <= 1'b0;
            rcon_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        logic [8*BYTES-1:0] capture;
        int unsigned        base;
        int unsigned        pos;
        logic [7:0]         byte_in;
        logic [7:0]         byte_out;

        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        inv_d    = inv_q;
        rcon_d   = rcon_q;
        capture  = '0;
        base     = 32'(cnt_q) * LANES;
        pos      = 0;
        byte_in  = 8'h00;
        byte_out = 8'h00;

        // RotWord is applied while capturing, so SUB only ever sees the working order.
        for (int unsigned k = 0; k < BYTES; k++) begin
            capture[8*k +: 8] = i_rot ? i_word[8*((k + 1) % BYTES) +: 8] : i_word[8*k +: 8];
        end

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    state_d = StSub;
                    cnt_d   = '0;
                    work_d  = capture;
                    inv_d   = i_inverse;
                    rcon_d  = i_rcon;
                end
            end
            StSub: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    pos      = base + l;
                    byte_in  = work_q[8*pos +: 8];
                    byte_out = inv_q ? InvSbox[byte_in] : FwdSbox[byte_in];
                    // Rcon lands after substitution and only on byte 0.
                    if (pos == 0) byte_out = byte_out ^ rcon_q;
                    work_d[8*pos +: 8] = byte_out;
                end
                if (cnt_q == CntW'(Chunks - 1)) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (i_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_ready = (state_q == StIdle) && i_rst_n;
    assign o_valid = (state_q == StHold);
    assign o_word  = work_q;

endmodule

// File: tb/tb_sub_word_engine.sv
// Self-checking bench: two engines (BYTES=4/LANES=1 and BYTES=16/LANES=4, both 4 chunks)
// share stimulus and are compared against a GF(2^8)-derived S-box model.
module tb_sub_word_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         ds_ready;
    logic [127:0] word_in;
    logic         inverse;
    logic         rot_in;
    logic [7:0]   rcon_in;

    logic         rdy4, val4, rdy16, val16;
    logic [31:0]  out4;
    logic [127:0] out16;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    sub_word_engine #(.BYTES(4), .LANES(1)) u_dut4 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (in_valid),
        .o_ready   (rdy4),
        .i_word    (word_in[31:0]),
        .i_inverse (inverse),
        .i_rot     (rot_in),
        .i_rcon    (rcon_in),
        .o_valid   (val4),
        .i_ready   (ds_ready),
        .o_word    (out4)
    );

    sub_word_engine #(.BYTES(16), .LANES(4)) u_dut16 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (in_valid),
        .o_ready   (rdy16),
        .i_word    (word_in),
        .i_inverse (inverse),
        .i_rot     (rot_in),
        .i_rcon    (rcon_in),
        .o_valid   (val16),
        .i_ready   (ds_ready),
        .o_word    (out16)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    // S(x) = affine(x^-1), inverse table by inverting the permutation.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            end
            s = iv ^ rotl1(iv) ^ rotl1(rotl1(iv)) ^ rotl1(rotl1(rotl1(iv)))
                ^ rotl1(rotl1(rotl1(rotl1(iv)))) ^ 8'h63;
            fwd_tab[x] = s;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_word(input logic [127:0] w, input int n, input bit inv,
                                              input bit rot, input logic [7:0] rc);
        logic [127:0] r = '0;
        for (int k = 0; k < n; k++) begin
            int         src = rot ? (k + 1) % n : k;
            logic [7:0] b   = w[8*src +: 8];
            logic [7:0] s   = inv ? inv_tab[b] : fwd_tab[b];
            if (k == 0) s = s ^ rc;
            r[8*k +: 8] = s;
        end
        return r;
    endfunction

    task automatic run_txn(input logic [127:0] w, input bit inv, input bit rot,
                           input logic [7:0] rc, input int hold, input bit toggle,
                           output logic [127:0] got4, output logic [127:0] got16);
        int           n;
        logic [127:0] m4;
        logic [127:0] m16;
        m4  = ref_word(w, 4, inv, rot, rc);
        m16 = ref_word(w, 16, inv, rot, rc);
        check_eq("ready_idle4", rdy4, 1'b1);
        check_eq("ready_idle16", rdy16, 1'b1);
        word_in  = w;
        inverse  = inv;
        rot_in   = rot;
        rcon_in  = rc;
        in_valid = 1'b1;
        ds_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (toggle) begin
            inverse = ~inv;
            rcon_in = rc ^ 8'h5a;
            rot_in  = ~rot;
            word_in = ~w;
        end
        check_eq("ready_busy", {rdy4, rdy16}, 2'b00);
        n = 0;
        while (!val4 && !val16 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", 128'(n), 128'd4);
        check_eq("valid_pair", {val4, val16}, 2'b11);
        check_eq("word4", out4, m4);
        check_eq("word16", out16, m16);
        got4  = {96'b0, out4};
        got16 = out16;
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check_eq("bp_valid", {val4, val16}, 2'b11);
                check_eq("bp_ready", {rdy4, rdy16}, 2'b00);
                check_eq("bp_word4", out4, m4);
                check_eq("bp_word16", out16, m16);
            end
            ds_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("valid_drop", {val4, val16}, 2'b00);
        check_eq("ready_back", {rdy4, rdy16}, 2'b11);
    endtask

    initial begin
        logic [127:0] g4;
        logic [127:0] g16;
        logic [127:0] w;
        build_tables();

        rst_n    = 1'b0;
        in_valid = 1'b0;
        ds_ready = 1'b1;
        word_in  = '0;
        inverse  = 1'b0;
        rot_in   = 1'b0;
        rcon_in  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {rdy4, rdy16}, 2'b00);
        check_eq("rst_valid", {val4, val16}, 2'b00);
        check_eq("rst_word4", out4, 32'h0);
        check_eq("rst_word16", out16, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_ready", {rdy4, rdy16}, 2'b11);

        // Key-schedule g function.
        run_txn(128'h3c4fcf09, 1'b0, 1'b1, 8'h01, 0, 1'b0, g4, g16);
        check_eq("keyexp", g4, 128'h01eb848b);

        // Inverse then forward round trip.
        run_txn(128'hed536300, 1'b1, 1'b0, 8'h00, 0, 1'b0, g4, g16);
        w = g4;
        run_txn(w, 1'b0, 1'b0, 8'h00, 0, 1'b0, g4, g16);
        check_eq("roundtrip", g4, 128'hed536300);

        // Full state of zeros.
        run_txn(128'h0, 1'b0, 1'b0, 8'h00, 0, 1'b0, g4, g16);
        check_eq("zeros16", g16, {16{8'h63}});
        run_txn(128'h0, 1'b0, 1'b0, 8'h1b, 0, 1'b0, g4, g16);
        check_eq("zeros16_rcon", g16, {{15{8'h63}}, 8'h78});

        // Backpressure and input latching.
        run_txn(128'h0123456789abcdeffedcba9876543210, 1'b0, 1'b1, 8'h36, 5, 1'b0, g4, g16);
        run_txn(128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0, 8'h80, 0, 1'b1, g4, g16);

        // Reset while chunk 2 is being processed.
        word_in  = {$urandom, $urandom, $urandom, $urandom};
        inverse  = 1'b0;
        rot_in   = 1'b0;
        rcon_in  = 8'h00;
        ds_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_ready", {rdy4, rdy16}, 2'b00);
        check_eq("midrst_word4", out4, 32'h0);
        check_eq("midrst_word16", out16, 128'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("midrst_novalid", {val4, val16}, 2'b00);
            check_eq("midrst_ready_back", {rdy4, rdy16}, 2'b11);
        end
        run_txn(128'h3c4fcf09, 1'b0, 1'b1, 8'h01, 0, 1'b0, g4, g16);
        check_eq("after_rst", g4, 128'h01eb848b);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            logic [7:0] rc;
            w  = {$urandom, $urandom, $urandom, $urandom};
            rc = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_txn(w, 1'($urandom), 1'($urandom), rc, int'($urandom_range(0, 3)),
                    1'($urandom), g4, g16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
